// File: rtl/sd_wb_slave_regs.sv
// Wishbone classic slave for the SD core's register map.
// It also holds the card-to-host read FIFO and the host-to-card write FIFO.
module sd_wb_slave_regs #(
  parameter int gWidth     = 32,
  parameter int gFifoDepth = 4
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              CYC_I,
  input  logic              STB_I,
  input  logic              WE_I,
  input  logic [2:0]        ADR_I,
  input  logic [gWidth-1:0] DAT_I,
  input  logic              SEL_I,
  input  logic [2:0]        CTI_I,
  output logic [gWidth-1:0] DAT_O,
  output logic              ACK_O,
  output logic              ERR_O,
  output logic              RTY_O,
  output logic              op_valid_o,
  input  logic              op_ready_i,
  output logic [1:0]        op_code_o,
  output logic [31:0]       start_addr_o,
  output logic [31:0]       end_addr_o,
  input  logic              busy_i,
  input  logic [gWidth-1:0] rd_data_i,
  input  logic              rd_valid_i,
  output logic              rd_ready_o,
  output logic [gWidth-1:0] wr_data_o,
  output logic              wr_valid_o,
  input  logic              wr_ready_i
);

  localparam int AW = $clog2(gFifoDepth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(gFifoDepth);

  logic              ack_q, err_q, rty_q;
  logic              ack_d, err_d, rty_d;
  logic [gWidth-1:0] dat_q, dat_d;
  logic              op_valid_q;
  logic [1:0]        op_code_q;
  logic [31:0]       start_q, end_q;

  logic [gWidth-1:0] rd_mem [gFifoDepth];
  logic [AW-1:0]     rd_wptr_q, rd_rptr_q;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic              rd_ready_q;

  logic [gWidth-1:0] wr_mem [gFifoDepth];
  logic [AW-1:0]     wr_wptr_q, wr_rptr_q;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;

  logic              req, cti_ok;
  logic              op_wr, start_wr, end_wr, rd_pop, wr_push;
  logic              rd_push, wr_pop;
  logic [gWidth-1:0] status_w;

  // A request is only accepted while no termination is on the bus.
  assign req    = CYC_I & STB_I & ~(ack_q | err_q | rty_q);
  assign cti_ok = (CTI_I == 3'b000) | (CTI_I == 3'b010) | (CTI_I == 3'b111);

  assign rd_push = rd_valid_i & rd_ready_q;
  assign wr_pop  = wr_valid_o & wr_ready_i;

  always_comb begin
    status_w      = '0;
    status_w[0]   = busy_i;
    status_w[1]   = op_valid_q;
    status_w[4:2] = 3'(rd_cnt_q);
    status_w[7:5] = 3'(wr_cnt_q);
  end

  always_comb begin
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rty_d    = 1'b0;
    dat_d    = '0;
    op_wr    = 1'b0;
    start_wr = 1'b0;
    end_wr   = 1'b0;
    rd_pop   = 1'b0;
    wr_push  = 1'b0;
    if (req) begin
      if (!cti_ok) begin
        err_d = 1'b1;
      end else if (WE_I) begin
        case (ADR_I)
          3'd0, 3'd1, 3'd2: begin
            if (!SEL_I) ack_d = 1'b1;
            else if (op_valid_q) rty_d = 1'b1;
            else begin
              ack_d    = 1'b1;
              op_wr    = (ADR_I == 3'd0);
              start_wr = (ADR_I == 3'd1);
              end_wr   = (ADR_I == 3'd2);
            end
          end
          3'd4: begin
            if (!SEL_I) ack_d = 1'b1;
            else if (wr_cnt_q == DEPTH) rty_d = 1'b1;
            else begin
              ack_d   = 1'b1;
              wr_push = 1'b1;
            end
          end
          default: err_d = 1'b1;
        endcase
      end else begin
        case (ADR_I)
          3'd0: begin ack_d = 1'b1; dat_d = gWidth'(op_code_q); end
          3'd1: begin ack_d = 1'b1; dat_d = gWidth'(start_q);   end
          3'd2: begin ack_d = 1'b1; dat_d = gWidth'(end_q);     end
          3'd3: begin
            if (rd_cnt_q == '0) err_d = 1'b1;
            else begin
              ack_d  = 1'b1;
              rd_pop = 1'b1;
              dat_d  = rd_mem[rd_rptr_q];
            end
          end
          3'd5:    begin ack_d = 1'b1; dat_d = status_w; end
          default: err_d = 1'b1;
        endcase
      end
    end
  end

  assign rd_cnt_d = rd_cnt_q + CW'(rd_push) - CW'(rd_pop);
  assign wr_cnt_d = wr_cnt_q + CW'(wr_push) - CW'(wr_pop);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rty_q      <= 1'b0;
      dat_q      <= '0;
      op_valid_q <= 1'b0;
      op_code_q  <= '0;
      start_q    <= '0;
      end_q      <= '0;
      rd_wptr_q  <= '0;
      rd_rptr_q  <= '0;
      rd_cnt_q   <= '0;
      rd_ready_q <= 1'b0;
      wr_wptr_q  <= '0;
      wr_rptr_q  <= '0;
      wr_cnt_q   <= '0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      rty_q <= rty_d;
      dat_q <= dat_d;
      if (op_wr) begin
        op_code_q  <= DAT_I[1:0];
        op_valid_q <= 1'b1;
      end else if (op_valid_q && op_ready_i) begin
        op_valid_q <= 1'b0;
      end
      if (start_wr) start_q <= 32'(DAT_I);
      if (end_wr)   end_q   <= 32'(DAT_I);
      if (rd_push) rd_wptr_q <= rd_wptr_q + AW'(1);
      if (rd_pop)  rd_rptr_q <= rd_rptr_q + AW'(1);
      if (wr_push) wr_wptr_q <= wr_wptr_q + AW'(1);
      if (wr_pop)  wr_rptr_q <= wr_rptr_q + AW'(1);
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      // Registered so it stays low while reset is held.
      rd_ready_q <= (rd_cnt_d < DEPTH);
    end
  end

  // FIFO storage needs no reset: the counts decide what is valid.
  always_ff @(posedge CLK_I) begin
    if (rd_push) rd_mem[rd_wptr_q] <= rd_data_i;
    if (wr_push) wr_mem[wr_wptr_q] <= DAT_I;
  end

  assign DAT_O        = dat_q;
  assign ACK_O        = ack_q;
  assign ERR_O        = err_q;
  assign RTY_O        = rty_q;
  assign op_valid_o   = op_valid_q;
  assign op_code_o    = op_code_q;
  assign start_addr_o = start_q;
  assign end_addr_o   = end_q;
  assign rd_ready_o   = rd_ready_q;
  assign wr_valid_o   = (wr_cnt_q != '0);
  assign wr_data_o    = wr_valid_o ? wr_mem[wr_rptr_q] : '0;

endmodule

// File: tb/tb_sd_wb_slave_regs.sv
// Bench for sd_wb_slave_regs: directed steps plus random traffic,
// checked against a queue-based model of the register map.
module tb_sd_wb_slave_regs;
  localparam int W = 32;
  localparam int D = 4;
  localparam logic [2:0] R_ACK = 3'b001;
  localparam logic [2:0] R_ERR = 3'b010;
  localparam logic [2:0] R_RTY = 3'b100;

  logic         clk = 1'b0;
  logic         rst;
  logic         cyc, stb, we, sel;
  logic [2:0]   adr, cti;
  logic [W-1:0] dat_i, dat_o;
  logic         ack, err, rty;
  logic         op_valid, op_ready;
  logic [1:0]   op_code;
  logic [31:0]  start_addr, end_addr;
  logic         busy;
  logic [W-1:0] rd_data, wr_data;
  logic         rd_valid, rd_ready, wr_valid, wr_ready;

  always #5 clk = ~clk;

  sd_wb_slave_regs #(.gWidth(W), .gFifoDepth(D)) dut (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we),
    .ADR_I(adr), .DAT_I(dat_i), .SEL_I(sel), .CTI_I(cti), .DAT_O(dat_o),
    .ACK_O(ack), .ERR_O(err), .RTY_O(rty),
    .op_valid_o(op_valid), .op_ready_i(op_ready), .op_code_o(op_code),
    .start_addr_o(start_addr), .end_addr_o(end_addr), .busy_i(busy),
    .rd_data_i(rd_data), .rd_valid_i(rd_valid), .rd_ready_o(rd_ready),
    .wr_data_o(wr_data), .wr_valid_o(wr_valid), .wr_ready_i(wr_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [1:0]  m_op_code;
  logic        m_op_valid;
  logic [31:0] m_start, m_end;
  logic [31:0] m_rdq[$];
  logic [31:0] m_wrq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_op_code = 2'd0; m_op_valid = 1'b0; m_start = 32'd0; m_end = 32'd0;
    m_rdq.delete(); m_wrq.delete();
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = {24'd0, 3'(m_wrq.size()), 3'(m_rdq.size()), m_op_valid, busy};
    return s;
  endfunction

  function automatic void model_xfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                                     input logic s, input logic [2:0] c,
                                     output logic [2:0] resp, output logic [31:0] rdat);
    resp = R_ERR;
    rdat = 32'd0;
    if (!(c inside {3'b000, 3'b010, 3'b111})) return;
    case (a)
      3'd0, 3'd1, 3'd2: begin
        if (w) begin
          if (!s) resp = R_ACK;
          else if (m_op_valid) resp = R_RTY;
          else begin
            resp = R_ACK;
            if (a == 3'd0) begin m_op_code = d[1:0]; m_op_valid = 1'b1; end
            else if (a == 3'd1) m_start = d;
            else m_end = d;
          end
        end else begin
          resp = R_ACK;
          rdat = (a == 3'd0) ? {30'd0, m_op_code} : (a == 3'd1) ? m_start : m_end;
        end
      end
      3'd3: if (!w && m_rdq.size() > 0) begin resp = R_ACK; rdat = m_rdq.pop_front(); end
      3'd4: if (w) begin
        if (!s) resp = R_ACK;
        else if (m_wrq.size() == D) resp = R_RTY;
        else begin resp = R_ACK; m_wrq.push_back(d); end
      end
      3'd5: if (!w) begin resp = R_ACK; rdat = model_status(); end
      default: ;
    endcase
  endfunction

  task automatic check_ctrl(input string tag);
    check({tag, " op_valid"}, op_valid, m_op_valid);
    check({tag, " op_code"}, op_code, m_op_code);
    check({tag, " start"}, start_addr, m_start);
    check({tag, " end"}, end_addr, m_end);
    check({tag, " rd_ready"}, rd_ready, m_rdq.size() < D);
    check({tag, " wr_valid"}, wr_valid, m_wrq.size() != 0);
  endtask

  task automatic bus(input string tag, input logic w, input logic [2:0] a, input logic [31:0] d,
                     input logic s, input logic [2:0] c);
    logic [2:0]  exp_resp;
    logic [31:0] exp_dat;
    @(posedge clk); #1;
    model_xfer(w, a, d, s, c, exp_resp, exp_dat);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s; cti = c;
    @(posedge clk); #1;
    // Strobe dropped right away: the termination must still appear.
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check({tag, " resp"}, {rty, err, ack}, exp_resp);
    check({tag, " dat"}, dat_o, exp_dat);
    $display("bus %s we=%0d adr=%0d dat=%h cti=%b -> resp=%b dat_o=%h", tag, w, a, d, c,
             {rty, err, ack}, dat_o);
    @(posedge clk); #1;
    check({tag, " idle"}, {rty, err, ack, dat_o}, 35'd0);
  endtask

  task automatic push_rd(input logic [31:0] d);
    logic exp_rdy;
    @(posedge clk); #1;
    exp_rdy = (m_rdq.size() < D);
    check("push_rd rd_ready", rd_ready, exp_rdy);
    rd_valid = 1'b1; rd_data = d;
    @(posedge clk); #1;
    rd_valid = 1'b0;
    if (exp_rdy) m_rdq.push_back(d);
    $display("ctl push_rd %h accepted=%0d", d, exp_rdy);
  endtask

  task automatic pop_wr();
    logic [31:0] head;
    @(posedge clk); #1;
    check("pop_wr wr_valid", wr_valid, m_wrq.size() != 0);
    head = (m_wrq.size() != 0) ? m_wrq[0] : 32'd0;
    check("pop_wr wr_data", wr_data, head);
    wr_ready = 1'b1;
    @(posedge clk); #1;
    wr_ready = 1'b0;
    if (m_wrq.size() != 0) void'(m_wrq.pop_front());
    $display("ctl pop_wr %h", head);
  endtask

  task automatic op_accept();
    @(posedge clk); #1;
    op_ready = 1'b1;
    @(posedge clk); #1;
    op_ready = 1'b0;
    m_op_valid = 1'b0;
    check("op_accept op_valid", op_valid, 1'b0);
    $display("ctl op_accept");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " term"}, {rty, err, ack}, 3'd0);
    check({tag, " dat_o"}, dat_o, 32'd0);
    check({tag, " op"}, {op_valid, op_code}, 3'd0);
    check({tag, " addrs"}, {start_addr, end_addr}, 64'd0);
    check({tag, " fifo"}, {rd_ready, wr_valid}, 2'd0);
    check({tag, " wr_data"}, wr_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [2:0]  rc;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 1'b1; adr = 3'd0; cti = 3'd0;
    dat_i = '0; op_ready = 1'b0; busy = 1'b0; rd_data = '0; rd_valid = 1'b0; wr_ready = 1'b0;
    model_reset();
    #2;
    check_all_zero("reset");
    @(negedge clk); rst = 1'b0;
    check("post-reset rd_ready low", rd_ready, 1'b0);
    @(posedge clk); #1;
    check("post-reset rd_ready high", rd_ready, 1'b1);

    // Register access
    bus("wr start", 1, 3'd1, 32'h1000, 1, 3'b000);
    bus("rd start", 0, 3'd1, 32'h0, 1, 3'b000);
    check_ctrl("regs");
    bus("sel0 start", 1, 3'd1, 32'hDEAD, 0, 3'b010);
    for (int i = 0; i < 3; i++) begin
      v = $urandom;
      bus("rnd wr end", 1, 3'd2, v, 1, (i == 1) ? 3'b111 : 3'b010);
      bus("rnd rd end", 0, 3'd2, 32'h0, 1, 3'b000);
    end
    check_ctrl("regs2");

    // Operation handshake and protection
    bus("wr op", 1, 3'd0, 32'h2, 1, 3'b000);
    check_ctrl("op pending");
    bus("wr start prot", 1, 3'd1, 32'h5555, 1, 3'b000);
    bus("wr end prot", 1, 3'd2, 32'h6666, 1, 3'b000);
    bus("rd op", 0, 3'd0, 32'h0, 1, 3'b000);
    busy = 1'b1;
    bus("rd status", 0, 3'd5, 32'h0, 1, 3'b000);
    busy = 1'b0;
    op_accept();
    check_ctrl("op done");

    // Read FIFO fill, overflow attempt, drain, underflow
    for (int i = 0; i < 5; i++) push_rd(32'hA1 + 32'(i));
    bus("status full", 0, 3'd5, 32'h0, 1, 3'b000);
    for (int i = 0; i < 5; i++) bus("rd fifo", 0, 3'd3, 32'h0, 1, 3'b000);

    // Write FIFO fill, retry, drain
    for (int i = 0; i < 5; i++) bus("wr fifo", 1, 3'd4, $urandom, 1, 3'b000);
    check_ctrl("wr full");
    pop_wr();
    bus("wr fifo retry", 1, 3'd4, 32'hBEEF0001, 1, 3'b000);
    for (int i = 0; i < 5; i++) pop_wr();

    // Illegal accesses
    push_rd(32'h77);
    bus("status pre", 0, 3'd5, 32'h0, 1, 3'b000);
    bus("rd adr6", 0, 3'd6, 32'h0, 1, 3'b000);
    bus("wr adr3", 1, 3'd3, 32'h1, 1, 3'b000);
    bus("rd adr4", 0, 3'd4, 32'h0, 1, 3'b000);
    bus("cti001", 1, 3'd1, 32'h9, 1, 3'b001);
    bus("wr adr7", 1, 3'd7, 32'h9, 1, 3'b000);
    bus("wr adr5", 1, 3'd5, 32'h9, 1, 3'b000);
    bus("status post", 0, 3'd5, 32'h0, 1, 3'b000);
    check_ctrl("illegal");

    // Random mixed traffic
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0, 1: push_rd($urandom);
        2:    pop_wr();
        3:    if (m_op_valid) op_accept(); else bus("rnd rd status", 0, 3'd5, 0, 1, 3'b000);
        default: begin
          case ($urandom_range(0, 4))
            0: rc = 3'b010;
            1: rc = 3'b111;
            2: rc = 3'(($urandom_range(0, 1) == 0) ? 3'b001 : 3'b101);
            default: rc = 3'b000;
          endcase
          busy = 1'($urandom_range(0, 1));
          bus("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, 1, rc);
        end
      endcase
    end
    check_ctrl("random");

    // Reset in the middle of a transfer with both FIFOs partly full
    if (m_op_valid) op_accept();
    while (m_rdq.size() > 0) bus("drain rd", 0, 3'd3, 0, 1, 3'b000);
    while (m_wrq.size() > 0) pop_wr();
    push_rd(32'hC1); push_rd(32'hC2);
    bus("pre-rst wr", 1, 3'd4, 32'hD1, 1, 3'b000);
    bus("pre-rst wr", 1, 3'd4, 32'hD2, 1, 3'b000);
    bus("pre-rst op", 1, 3'd0, 32'h1, 1, 3'b000);
    busy = 1'b0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 3'd3; cti = 3'b000;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    check("mid ack before rst", ack, 1'b1);
    #2; rst = 1'b1; #1;
    check_all_zero("async rst");
    model_reset();
    @(negedge clk); rst = 1'b0;
    bus("status after rst", 0, 3'd5, 32'h0, 1, 3'b000);
    check_ctrl("after rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
